// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
//   Bundles the command stream, the response stream and the APB bus that
//   surround apb_master_bridge.
//
//   Modports:
//     master - the bridge side. It takes commands, drives the APB requester
//              signals and returns responses.
//     slave  - the environment side. It issues commands, consumes responses
//              and models the APB completer.
//
//   Signals:
//     cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata      command stream
//     rsp_valid/rsp_ready/rsp_rdata/rsp_err/rsp_timeout     response stream
//     psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr APB bus
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 16
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;

   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  rsp_ready,
      input  prdata, pready, pslverr,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output psel, penable, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output rsp_ready,
      output prdata, pready, pslverr,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB requester. It takes one command from a
//   valid/ready stream, runs the APB SETUP and ACCESS phases, and returns one
//   response record. Wait states (pready low) and pslverr are honoured. A
//   transfer is aborted when the slave holds pready low for TIMEOUT
//   consecutive ACCESS cycles. TIMEOUT = 0 waits forever.
//
//   Ports:
//     clk     - single clock for the bridge and the APB bus
//     preset  - synchronous, active-high reset. It discards any transfer or
//               pending response.
//     bus     - apb_master_bridge_if.master
//               (command stream, response stream and APB bus)
//
//   All outputs are registered except cmd_ready. cmd_ready is
//   (state == IDLE) && !preset.
module apb_master_bridge #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                preset,
   apb_master_bridge_if.master bus
);

   // The counter must reach TIMEOUT-1. It is kept at least 1 bit wide so
   // that it still exists when the timeout is disabled.
   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t             state_reg,       state_next;
   logic [CNT_W-1:0]   wait_cnt_reg,    wait_cnt_next;
   logic               psel_reg,        psel_next;
   logic               penable_reg,     penable_next;
   logic               pwrite_reg,      pwrite_next;
   logic [ADDR_W-1:0]  paddr_reg,       paddr_next;
   logic [DATA_W-1:0]  pwdata_reg,      pwdata_next;
   logic               rsp_valid_reg,   rsp_valid_next;
   logic [DATA_W-1:0]  rsp_rdata_reg,   rsp_rdata_next;
   logic               rsp_err_reg,     rsp_err_next;
   logic               rsp_timeout_reg, rsp_timeout_next;
   logic               cmd_ready;

   assign cmd_ready = (state_reg == ST_IDLE) && !preset;

   assign bus.cmd_ready   = cmd_ready;
   assign bus.psel        = psel_reg;
   assign bus.penable     = penable_reg;
   assign bus.pwrite      = pwrite_reg;
   assign bus.paddr       = paddr_reg;
   assign bus.pwdata      = pwdata_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_rdata   = rsp_rdata_reg;
   assign bus.rsp_err     = rsp_err_reg;
   assign bus.rsp_timeout = rsp_timeout_reg;

   // Next-state and next-output logic. Every register holds its value unless
   // a branch below overrides it. This keeps the paddr, pwrite and pwdata
   // values and the response fields stable while they are held.
   always_comb begin
      state_next       = state_reg;
      wait_cnt_next    = wait_cnt_reg;
      psel_next        = psel_reg;
      penable_next     = penable_reg;
      pwrite_next      = pwrite_reg;
      paddr_next       = paddr_reg;
      pwdata_next      = pwdata_reg;
      rsp_valid_next   = rsp_valid_reg;
      rsp_rdata_next   = rsp_rdata_reg;
      rsp_err_next     = rsp_err_reg;
      rsp_timeout_next = rsp_timeout_reg;

      case (state_reg)
         ST_IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               state_next    = ST_SETUP;
               wait_cnt_next = '0;
               psel_next     = 1'b1;
               penable_next  = 1'b0;
               pwrite_next   = bus.cmd_write;
               paddr_next    = bus.cmd_addr;
               pwdata_next   = bus.cmd_write ? bus.cmd_wdata : '0;
            end
         end

         ST_SETUP: begin
            state_next   = ST_ACCESS;
            penable_next = 1'b1;
         end

         ST_ACCESS: begin
            if (bus.pready) begin
               // A completion wins over a timeout that falls on the same cycle.
               state_next       = ST_RESP;
               psel_next        = 1'b0;
               penable_next     = 1'b0;
               rsp_valid_next   = 1'b1;
               rsp_rdata_next   = pwrite_reg ? '0 : bus.prdata;
               rsp_err_next     = bus.pslverr;
               rsp_timeout_next = 1'b0;
            end else begin
               wait_cnt_next = wait_cnt_reg + CNT_W'(1);
               // wait_cnt_reg counts the earlier low cycles, so this cycle is
               // the TIMEOUT-th one when the count equals TIMEOUT-1.
               if ((TIMEOUT != 0) && (wait_cnt_reg == TIMEOUT_LAST)) begin
                  state_next       = ST_RESP;
                  psel_next        = 1'b0;
                  penable_next     = 1'b0;
                  rsp_valid_next   = 1'b1;
                  rsp_rdata_next   = '0;
                  rsp_err_next     = 1'b1;
                  rsp_timeout_next = 1'b1;
               end
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_next     = ST_IDLE;
               rsp_valid_next = 1'b0;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (preset) begin
         state_reg       <= ST_IDLE;
         wait_cnt_reg    <= '0;
         psel_reg        <= 1'b0;
         penable_reg     <= 1'b0;
         pwrite_reg      <= 1'b0;
         paddr_reg       <= '0;
         pwdata_reg      <= '0;
         rsp_valid_reg   <= 1'b0;
         rsp_rdata_reg   <= '0;
         rsp_err_reg     <= 1'b0;
         rsp_timeout_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wait_cnt_reg    <= wait_cnt_next;
         psel_reg        <= psel_next;
         penable_reg     <= penable_next;
         pwrite_reg      <= pwrite_next;
         paddr_reg       <= paddr_next;
         pwdata_reg      <= pwdata_next;
         rsp_valid_reg   <= rsp_valid_next;
         rsp_rdata_reg   <= rsp_rdata_next;
         rsp_err_reg     <= rsp_err_next;
         rsp_timeout_reg <= rsp_timeout_next;
      end
   end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with TIMEOUT = 4. It drives commands
//   through the interface and plays the APB slave by hand. Each comparison is
//   an immediate assertion against a hand-computed value.
module tb_apb_master_bridge;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 16;

   logic clk;
   logic preset;
   int   n_checks;
   int   n_pass;

   apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   apb_master_bridge #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (4)
   ) dut (
      .clk    (clk),
      .preset (preset),
      .bus    (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge, then settle away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
   endtask

   // Issue one command and act as the slave until the response appears.
   // n_wait < 0 keeps pready low for good.
   // Outputs:
   //   acc_cyc  - cycles spent waiting for cmd_ready
   //   psel_cyc - number of cycles with psel high
   //   pen_cyc  - number of cycles with penable high
   //   lat      - cycle (after the accept edge) in which rsp_valid first appears
   task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                           input int n_wait, input logic [15:0] rd, input logic err,
                           output int acc_cyc, output int psel_cyc, output int pen_cyc,
                           output int lat);
      bit accepted;
      bit done;
      accepted = 1'b0;
      done     = 1'b0;
      acc_cyc  = 0;
      psel_cyc = 0;
      pen_cyc  = 0;
      lat      = 0;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = wr;
      bus_if.cmd_addr  = addr;
      bus_if.cmd_wdata = wd;
      for (int i = 0; i < 20; i++) begin
         if (bus_if.cmd_ready) begin
            step();
            accepted = 1'b1;
            break;
         end
         acc_cyc++;
         step();
      end
      chk("accept", 32'(accepted), 32'd1);
      // Scramble the command after acceptance; the bridge must use latched values.
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_write = ~wr;
      bus_if.cmd_addr  = 32'hDEAD_BEEF;
      bus_if.cmd_wdata = 16'hBAD0;
      bus_if.prdata    = rd;
      bus_if.pslverr   = err;
      for (int k = 1; k <= 40; k++) begin
         chk("psel_with_rsp", 32'(bus_if.psel & bus_if.rsp_valid), 32'd0);
         if (bus_if.rsp_valid) begin
            lat  = k;
            done = 1'b1;
            break;
         end
         if (bus_if.psel) begin
            psel_cyc++;
            chk("paddr",  bus_if.paddr,          addr);
            chk("pwrite", 32'(bus_if.pwrite),    32'(wr));
            chk("pwdata", 32'(bus_if.pwdata),    wr ? 32'(wd) : 32'd0);
         end
         if (bus_if.penable) begin
            pen_cyc++;
            bus_if.pready = (n_wait >= 0) && (pen_cyc > n_wait);
         end else begin
            bus_if.pready = 1'b0;
         end
         step();
      end
      chk("xfer_done", 32'(done), 32'd1);
      bus_if.pready  = 1'b0;
      bus_if.pslverr = 1'b0;
      $display("xfer wr=%0d addr=%h wdata=%h -> rdata=%h err=%0d timeout=%0d psel=%0d penable=%0d lat=%0d",
               wr, addr, wd, bus_if.rsp_rdata, bus_if.rsp_err, bus_if.rsp_timeout,
               psel_cyc, pen_cyc, lat);
   endtask

   initial begin
      int acc;
      int ps;
      int pe;
      int lt;

      n_checks = 0;
      n_pass   = 0;
      preset            = 1'b1;
      bus_if.cmd_valid  = 1'b0;
      bus_if.cmd_write  = 1'b0;
      bus_if.cmd_addr   = '0;
      bus_if.cmd_wdata  = '0;
      bus_if.rsp_ready  = 1'b1;
      bus_if.prdata     = '0;
      bus_if.pready     = 1'b0;
      bus_if.pslverr    = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_psel",      32'(bus_if.psel),        32'd0);
      chk("rst_penable",   32'(bus_if.penable),     32'd0);
      chk("rst_rsp_valid", 32'(bus_if.rsp_valid),   32'd0);
      chk("rst_rsp_err",   32'(bus_if.rsp_err),     32'd0);
      chk("rst_paddr",     bus_if.paddr,            32'd0);
      chk("rst_cmd_ready", 32'(bus_if.cmd_ready),   32'd0);
      preset = 1'b0;
      #1;
      chk("idle_cmd_ready", 32'(bus_if.cmd_ready),  32'd1);

      // 1: zero-wait write to 0x600
      run_xfer(1'b1, 32'h600, 16'h00A5, 0, 16'h0000, 1'b0, acc, ps, pe, lt);
      chk("t1_psel_cycles", 32'(ps), 32'd2);
      chk("t1_pen_cycles",  32'(pe), 32'd1);
      chk("t1_latency",     32'(lt), 32'd3);
      chk("t1_rsp_err",     32'(bus_if.rsp_err),     32'd0);
      chk("t1_rsp_rdata",   32'(bus_if.rsp_rdata),   32'd0);
      chk("t1_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
      step();
      chk("t1_rsp_drop",    32'(bus_if.rsp_valid),   32'd0);
      chk("t1_ready_again", 32'(bus_if.cmd_ready),   32'd1);

      // 2: read 0x604 with two wait states
      run_xfer(1'b0, 32'h604, 16'hFFFF, 2, 16'h1234, 1'b0, acc, ps, pe, lt);
      chk("t2_acc_cycles",  32'(acc), 32'd0);
      chk("t2_pen_cycles",  32'(pe),  32'd3);
      chk("t2_latency",     32'(lt),  32'd5);
      chk("t2_rsp_rdata",   32'(bus_if.rsp_rdata), 32'h1234);
      chk("t2_rsp_err",     32'(bus_if.rsp_err),   32'd0);
      step();

      // 3: read 0x700 with a slave error
      run_xfer(1'b0, 32'h700, 16'h0000, 0, 16'hFFFF, 1'b1, acc, ps, pe, lt);
      chk("t3_rsp_err",     32'(bus_if.rsp_err),     32'd1);
      chk("t3_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
      chk("t3_rsp_rdata",   32'(bus_if.rsp_rdata),   32'hFFFF);
      step();

      // 4a: the slave never becomes ready, so the transfer times out after 4 cycles
      run_xfer(1'b0, 32'h606, 16'h0000, -1, 16'hBEEF, 1'b0, acc, ps, pe, lt);
      chk("t4a_pen_cycles",  32'(pe), 32'd4);
      chk("t4a_latency",     32'(lt), 32'd6);
      chk("t4a_psel_low",    32'(bus_if.psel),        32'd0);
      chk("t4a_rsp_err",     32'(bus_if.rsp_err),     32'd1);
      chk("t4a_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd1);
      chk("t4a_rsp_rdata",   32'(bus_if.rsp_rdata),   32'd0);
      step();

      // 4b: pready arrives on the 4th low cycle; completion wins over the timeout
      run_xfer(1'b0, 32'h606, 16'h0000, 3, 16'h5A5A, 1'b0, acc, ps, pe, lt);
      chk("t4b_pen_cycles",  32'(pe), 32'd4);
      chk("t4b_rsp_err",     32'(bus_if.rsp_err),     32'd0);
      chk("t4b_rsp_timeout", 32'(bus_if.rsp_timeout), 32'd0);
      chk("t4b_rsp_rdata",   32'(bus_if.rsp_rdata),   32'h5A5A);
      step();

      // 5: response back-pressure while a new command is already waiting
      bus_if.rsp_ready = 1'b0;
      run_xfer(1'b0, 32'h602, 16'h0000, 0, 16'h0042, 1'b0, acc, ps, pe, lt);
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b1;
      bus_if.cmd_addr  = 32'h606;
      bus_if.cmd_wdata = 16'h7E7E;
      bus_if.prdata    = 16'h9999;
      for (int i = 0; i < 5; i++) begin
         chk("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
         chk("t5_rsp_rdata", 32'(bus_if.rsp_rdata), 32'h0042);
         chk("t5_rsp_err",   32'(bus_if.rsp_err),   32'd0);
         chk("t5_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
         chk("t5_psel",      32'(bus_if.psel),      32'd0);
         step();
      end
      chk("t5_still_held", 32'(bus_if.rsp_valid), 32'd1);
      bus_if.rsp_ready = 1'b1;
      step();
      chk("t5_rsp_drop",  32'(bus_if.rsp_valid), 32'd0);
      chk("t5_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      run_xfer(1'b1, 32'h606, 16'h7E7E, 0, 16'h0000, 1'b0, acc, ps, pe, lt);
      chk("t5_next_acc",  32'(acc), 32'd0);
      chk("t5_next_lat",  32'(lt),  32'd3);
      step();

      // 6: reset during the ACCESS phase of a write
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = 1'b1;
      bus_if.cmd_addr  = 32'h604;
      bus_if.cmd_wdata = 16'h1111;
      bus_if.pready    = 1'b0;
      chk("t6_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      step();
      bus_if.cmd_valid = 1'b0;
      chk("t6_setup_psel", 32'(bus_if.psel), 32'd1);
      step();
      chk("t6_access_pen", 32'(bus_if.penable), 32'd1);
      preset = 1'b1;
      step();
      chk("t6_rst_psel",    32'(bus_if.psel),      32'd0);
      chk("t6_rst_penable", 32'(bus_if.penable),   32'd0);
      chk("t6_rst_valid",   32'(bus_if.rsp_valid), 32'd0);
      preset = 1'b0;
      bus_if.pready = 1'b1;
      #1;
      chk("t6_ready_after_rst", 32'(bus_if.cmd_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t6_no_rsp",  32'(bus_if.rsp_valid), 32'd0);
         chk("t6_no_psel", 32'(bus_if.psel),      32'd0);
      end
      bus_if.pready = 1'b0;
      run_xfer(1'b1, 32'h606, 16'h0F0F, 0, 16'h0000, 1'b0, acc, ps, pe, lt);
      chk("t6_new_psel_cycles", 32'(ps), 32'd2);
      chk("t6_new_pen_cycles",  32'(pe), 32'd1);
      chk("t6_new_rsp_err",     32'(bus_if.rsp_err), 32'd0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
